// File: rtl/fm_pkg.sv
// Shared definitions for the FM generator core: scheduler state encoding and
// default geometry used by the operator pipeline and the register block.
package fm_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam int FM_NUM_OPS = 16;
  localparam int FM_OP_CYC  = 4;
  localparam int FM_PW      = 32;

endpackage

// File: rtl/fm_sat_cnt16.sv
// 16-bit event counter with synchronous clear; SATURATE selects holding at
// 0xFFFF instead of wrapping.
module fm_sat_cnt16 #(
  parameter bit SATURATE = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !(SATURATE && (cnt == 16'hFFFF))) begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/fm_op_sched.sv
// Per-sample frame scheduler for the operator pipeline; also serialises
// parameter RAM commits so they only land between frames.
module fm_op_sched
  import fm_pkg::*;
#(
  parameter int NUM_OPS = FM_NUM_OPS,
  parameter int OP_CYC  = FM_OP_CYC,
  parameter int PW      = FM_PW,
  parameter int AW      = $clog2(NUM_OPS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          samp_ena,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_op,
  input  logic [PW-1:0] wr_data,
  input  logic          trig_in,
  input  logic          clr_err,
  output logic [AW-1:0] op_idx,
  output logic          op_valid,
  output logic          op_first,
  output logic          op_last,
  output logic          ram_we,
  output logic [AW-1:0] ram_waddr,
  output logic [PW-1:0] ram_wdata,
  output logic          gate,
  output logic          wr_busy,
  output logic          wr_err,
  output logic [31:0]   diag
);

  localparam int SW = (OP_CYC > 1) ? $clog2(OP_CYC) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(OP_CYC - 1);
  localparam logic [AW-1:0] OP_LAST   = AW'(NUM_OPS - 1);

  logic [1:0]    state, state_nx;
  logic [SW-1:0] slot;
  logic [AW-1:0] pend_op;
  logic [PW-1:0] pend_data;
  logic          start_pend;
  logic          wr_take, wr_drop, wr_pend_eff, frame_done, run_enter;
  logic [15:0]   frame_cnt, overrun_cnt;

  // The commit is retired in the cycle ram_we is high, so that cycle can
  // already accept a fresh request and no longer counts as pending.
  assign wr_take     = wr_req && (!wr_busy || ram_we);
  assign wr_drop     = wr_req && wr_busy && !ram_we;
  assign wr_pend_eff = (wr_busy && !ram_we) || wr_take;
  assign frame_done  = (state == ST_RUN) && (slot == SLOT_LAST) && (op_idx == OP_LAST);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (wr_pend_eff)                state_nx = ST_WRITE;
        else if (samp_ena || start_pend) state_nx = ST_RUN;
      end
      ST_WRITE: state_nx = ST_IDLE;
      ST_RUN:   if (frame_done) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  assign run_enter = (state != ST_RUN) && (state_nx == ST_RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      slot       <= '0;
      op_idx     <= '0;
      op_valid   <= 1'b0;
      op_first   <= 1'b0;
      op_last    <= 1'b0;
      ram_we     <= 1'b0;
      ram_waddr  <= '0;
      ram_wdata  <= '0;
      gate       <= 1'b0;
      wr_busy    <= 1'b0;
      wr_err     <= 1'b0;
      pend_op    <= '0;
      pend_data  <= '0;
      start_pend <= 1'b0;
    end else begin
      state  <= state_nx;
      ram_we <= (state == ST_WRITE);
      if (state == ST_WRITE) begin
        ram_waddr <= pend_op;
        ram_wdata <= pend_data;
      end

      if (wr_take) begin
        pend_op   <= wr_op;
        pend_data <= wr_data;
        wr_busy   <= 1'b1;
      end else if (ram_we) begin
        wr_busy <= 1'b0;
      end

      if (clr_err)      wr_err <= 1'b0;
      else if (wr_drop) wr_err <= 1'b1;

      if (run_enter)                         start_pend <= 1'b0;
      else if (samp_ena && state != ST_RUN)  start_pend <= 1'b1;

      if (run_enter) begin
        op_valid <= 1'b1;
        op_idx   <= '0;
        slot     <= '0;
        op_first <= 1'b1;
        op_last  <= 1'b0;
        gate     <= trig_in;
      end else if (state == ST_RUN) begin
        op_first <= 1'b0;
        if (frame_done) begin
          op_valid <= 1'b0;
          op_last  <= 1'b0;
          op_idx   <= '0;
          slot     <= '0;
        end else if (slot == SLOT_LAST) begin
          slot    <= '0;
          op_idx  <= op_idx + 1'b1;
          op_last <= ((op_idx + 1'b1) == OP_LAST) && (SLOT_LAST == '0);
        end else begin
          slot    <= slot + 1'b1;
          op_last <= (op_idx == OP_LAST) && ((slot + 1'b1) == SLOT_LAST);
        end
      end
    end
  end

  fm_sat_cnt16 #(.SATURATE(1'b0)) u_frame_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (frame_done),
    .cnt   (frame_cnt)
  );

  fm_sat_cnt16 #(.SATURATE(1'b1)) u_overrun_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_err),
    .inc   (samp_ena && (state == ST_RUN)),
    .cnt   (overrun_cnt)
  );

  assign diag = {overrun_cnt, frame_cnt};

endmodule

// File: tb/tb_fm_op_sched.sv
// Directed bench for fm_op_sched: frame timing, commit ordering, overrun,
// gate latching and asynchronous reset, with a write scoreboard.
module tb_fm_op_sched;

  localparam int NOPS = 16;
  localparam int OPC  = 4;
  localparam int PW   = 32;
  localparam int AW   = 4;
  localparam int FLEN = NOPS * OPC;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          samp_ena = 1'b0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_op = '0;
  logic [PW-1:0] wr_data = '0;
  logic          trig_in = 1'b0;
  logic          clr_err = 1'b0;
  logic [AW-1:0] op_idx;
  logic          op_valid, op_first, op_last, ram_we, gate, wr_busy, wr_err;
  logic [AW-1:0] ram_waddr;
  logic [PW-1:0] ram_wdata;
  logic [31:0]   diag;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;
  logic [AW+PW-1:0] exp_q[$];

  always #5 clk = ~clk;

  fm_op_sched #(.NUM_OPS(NOPS), .OP_CYC(OPC), .PW(PW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .samp_ena(samp_ena), .wr_req(wr_req),
    .wr_op(wr_op), .wr_data(wr_data), .trig_in(trig_in), .clr_err(clr_err),
    .op_idx(op_idx), .op_valid(op_valid), .op_first(op_first), .op_last(op_last),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .gate(gate),
    .wr_busy(wr_busy), .wr_err(wr_err), .diag(diag)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [AW-1:0] op, input logic [PW-1:0] d, input bit expect_write);
    wr_req  = 1'b1;
    wr_op   = op;
    wr_data = d;
    if (expect_write) exp_q.push_back({op, d});
  endtask

  task automatic check_zero(input string tag);
    check({tag, " outs"}, 64'({op_idx, op_valid, op_first, op_last, ram_we, gate, wr_busy, wr_err}), 64'd0);
    check({tag, " diag"}, 64'(diag), 64'd0);
  endtask

  // Called in the first frame cycle; returns in the first cycle after op_valid falls.
  task automatic run_frame(input string tag, input logic exp_gate, input int commit_cyc,
                           input logic [AW-1:0] cop, input logic [PW-1:0] cdata,
                           input logic [63:0] samp_mask, input int trig_cyc);
    int bad = 0;
    for (int c = 0; c < FLEN; c++) begin
      if (op_valid !== 1'b1 || op_idx !== AW'(c / OPC) || op_first !== (c == 0) ||
          op_last !== (c == FLEN - 1) || ram_we !== 1'b0 || gate !== exp_gate)
        bad++;
      if (c == commit_cyc) commit(cop, cdata, 1'b1);
      samp_ena = samp_mask[c];
      if (c == trig_cyc) trig_in = ~trig_in;
      step();
      wr_req   = 1'b0;
      samp_ena = 1'b0;
    end
    check({tag, " frame body bad cycles"}, 64'(bad), 64'd0);
    check({tag, " op_valid falls"}, 64'(op_valid), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!reset && ram_we === 1'b1) begin
      if (exp_q.size() == 0) check("ram_we unexpected", 64'(ram_we), 64'd0);
      else check("ram write addr/data", 64'({ram_waddr, ram_wdata}), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    int bad;
    repeat (3) step();
    check_zero("in reset");
    reset = 1'b0;
    step();
    check_zero("after reset");

    // Single frame
    trig_in = 1'b1;
    samp_ena = 1'b1;
    step();
    samp_ena = 1'b0;
    check("f1 first cycle", 64'({op_valid, op_first, op_idx}), 64'({1'b1, 1'b1, 4'd0}));
    run_frame("f1", 1'b1, -1, '0, '0, 64'd0, -1);
    check("f1 diag", 64'(diag), 64'h1);

    // Commit during RUN lands two cycles after op_valid falls
    step();
    samp_ena = 1'b1;
    step();
    samp_ena = 1'b0;
    run_frame("f2", 1'b1, 10, 4'd3, 32'hDEADBEEF, 64'd0, -1);
    check("f2 busy at frame end", 64'(wr_busy), 64'd1);
    step();
    check("f2 we at F+1", 64'(ram_we), 64'd0);
    step();
    check("f2 we at F+2", 64'(ram_we), 64'd1);
    step();
    check("f2 busy cleared", 64'({ram_we, wr_busy}), 64'd0);
    check("f2 diag", 64'(diag), 64'h2);

    // Commit and sample strobe together: write first, frame right after
    commit(4'd5, 32'h55AA0005, 1'b1);
    samp_ena = 1'b1;
    step();
    wr_req = 1'b0;
    samp_ena = 1'b0;
    check("c+s t+1 busy/valid", 64'({wr_busy, op_valid}), 64'({1'b1, 1'b0}));
    step();
    check("c+s t+2 we/valid", 64'({ram_we, op_valid}), 64'({1'b1, 1'b0}));
    step();
    check("c+s t+3 busy", 64'(wr_busy), 64'd0);
    run_frame("f3", 1'b1, -1, '0, '0, 64'd0, -1);
    check("f3 diag", 64'(diag), 64'h3);

    // Double commit: second is dropped, error is sticky until cleared
    step();
    commit(4'd1, 32'h11, 1'b1);
    step();
    commit(4'd2, 32'h22, 1'b0);
    step();
    wr_req = 1'b0;
    check("dbl err set", 64'({ram_we, wr_err}), 64'({1'b1, 1'b1}));
    step();
    check("dbl busy/err", 64'({wr_busy, wr_err}), 64'({1'b0, 1'b1}));
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("clr_err", 64'(wr_err), 64'd0);

    // Request arriving in the retire cycle becomes the next commit
    commit(4'd6, 32'h66, 1'b1);
    step();
    wr_req = 1'b0;
    step();
    commit(4'd7, 32'h77, 1'b1);
    step();
    wr_req = 1'b0;
    check("retire-cycle accept", 64'({wr_busy, wr_err, ram_we}), 64'({1'b1, 1'b0, 1'b0}));
    step();
    check("retire-cycle write", 64'(ram_we), 64'd1);
    step();
    check("retire-cycle done", 64'(wr_busy), 64'd0);

    // Overruns inside a frame and trigger toggled mid-frame
    samp_ena = 1'b1;
    step();
    samp_ena = 1'b0;
    run_frame("f4", 1'b1, -1, '0, '0, (64'd1 << 5) | (64'd1 << 20) | (64'd1 << 40), 30);
    check("f4 diag", 64'(diag), 64'({16'd3, 16'd4}));
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (op_valid !== 1'b0) bad++;
    end
    check("no extra frame after overrun", 64'(bad), 64'd0);
    samp_ena = 1'b1;
    step();
    samp_ena = 1'b0;
    check("f5 gate relatched", 64'(gate), 64'd0);
    run_frame("f5", 1'b0, -1, '0, '0, 64'd1 << 63, -1);
    check("f5 diag", 64'(diag), 64'({16'd4, 16'd5}));
    step();
    check("last-cycle strobe ignored", 64'(op_valid), 64'd0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("overrun cleared", 64'(diag), 64'({16'd0, 16'd5}));

    // Reset mid-frame with a commit pending
    samp_ena = 1'b1;
    step();
    samp_ena = 1'b0;
    check("f6 start", 64'({op_valid, op_first}), 64'({1'b1, 1'b1}));
    commit(4'd9, 32'h99, 1'b0);
    step();
    wr_req = 1'b0;
    repeat (27) step();
    check("f6 at op 7", 64'({op_idx, wr_busy}), 64'({4'd7, 1'b1}));
    reset = 1'b1;
    #1;
    check_zero("async reset");
    step();
    step();
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ram_we !== 1'b0 || op_valid !== 1'b0 || wr_busy !== 1'b0) bad++;
    end
    check("post-reset quiet", 64'(bad), 64'd0);
    check("post-reset diag", 64'(diag), 64'd0);
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
